// File: rtl/io_poll_master_pkg.sv
// Shared processor definitions: MMIO map and poll-sequencer state encoding.
package io_poll_master_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_SW   = 4'd1,
        S_CAP_SW  = 4'd2,
        S_RD_KEY  = 4'd3,
        S_CAP_KEY = 4'd4,
        S_WR_LEDR = 4'd5,
        S_WR_LEDG = 4'd6,
        S_WR_HEX  = 4'd7,
        S_WAIT    = 4'd8
    } state_t;

    localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

    // The sequencer is idle only while parked or waiting between polls.
    function automatic logic is_busy(state_t s);
        return !((s == S_IDLE) || (s == S_WAIT));
    endfunction

endpackage

// File: rtl/io_poll_master_if.sv
// DataMemory bus between the poll master and the memory-mapped IO space.
interface io_poll_master_if #(
    parameter int DBITS = 32
);
    logic             wrMEM;
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] dataIn;
    logic [DBITS-1:0] dataOut;

    modport master (output wrMEM, output addr, output dataIn, input dataOut);
    modport slave  (input wrMEM, input addr, input dataIn, output dataOut);
endinterface

// File: rtl/io_poll_master_key_press_counter.sv
// Key capture, rising-edge detect and wrapping 16-bit press counter.
module key_press_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap,
    input  logic [3:0]  key_new,
    output logic [3:0]  key_reg,
    output logic [15:0] count
);
    logic [3:0] key_prev;
    logic       cap_d;

    // Capture keys on the strobe; count one event per capture with any rising bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg  <= '0;
            key_prev <= '0;
            cap_d    <= 1'b0;
            count    <= '0;
        end else begin
            cap_d <= cap;
            if (cap) begin
                key_prev <= key_reg;
                key_reg  <= key_new;
            end
            // Compare the freshly captured pair one cycle later; any number of
            // simultaneous rising bits is still a single press event.
            if (cap_d && ((~key_prev & key_reg) != 4'b0000))
                count <= count + 16'd1;
        end
    end
endmodule

// File: rtl/io_poll_master.sv
// Polls switches and keys over the DataMemory bus and mirrors them to LEDs/HEX.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | parked, waiting for en
// S_RD_SW   | switch address presented
// S_CAP_SW  | switch read data captured
// S_RD_KEY  | key address presented
// S_CAP_KEY | key read data captured
// S_WR_LEDR | switch image written to red LEDs
// S_WR_LEDG | key image written to green LEDs
// S_WR_HEX  | press count written to HEX display
// S_WAIT    | POLL_WAIT idle cycles before the next poll
module io_poll_master #(
    parameter logic [31:0] POLL_WAIT = 32'd1000,
    parameter int          DBITS     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    io_poll_master_if.master     bus,
    output logic [15:0]          keyCount,
    output logic                 busy
);
    import io_poll_master_pkg::*;

    state_t      state;
    logic [9:0]  sw_reg;
    logic [31:0] wait_cnt;
    logic [3:0]  key_reg;
    logic        key_cap;

    assign key_cap = (state == S_CAP_KEY);
    assign busy    = is_busy(state);

    key_press_counter u_kpc (
        .clk     (clk),
        .reset   (reset),
        .cap     (key_cap),
        .key_new (bus.dataOut[3:0]),
        .key_reg (key_reg),
        .count   (keyCount)
    );

    // Sequencer with bus outputs registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bus.wrMEM  <= 1'b0;
            bus.addr   <= '0;
            bus.dataIn <= '0;
            sw_reg     <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state    <= S_RD_SW;
                        bus.addr <= DBITS'(ADDR_SW);
                    end
                end
                S_RD_SW:  state <= S_CAP_SW;
                S_CAP_SW: begin
                    sw_reg   <= bus.dataOut[9:0];
                    state    <= S_RD_KEY;
                    bus.addr <= DBITS'(ADDR_KEY);
                end
                S_RD_KEY: state <= S_CAP_KEY;
                S_CAP_KEY: begin
                    state      <= S_WR_LEDR;
                    bus.wrMEM  <= 1'b1;
                    bus.addr   <= DBITS'(ADDR_LEDR);
                    bus.dataIn <= DBITS'(sw_reg);
                end
                S_WR_LEDR: begin
                    state      <= S_WR_LEDG;
                    bus.addr   <= DBITS'(ADDR_LEDG);
                    bus.dataIn <= DBITS'(key_reg);
                end
                // keyCount has absorbed this poll's press by the end of S_WR_LEDR.
                S_WR_LEDG: begin
                    state      <= S_WR_HEX;
                    bus.addr   <= DBITS'(ADDR_HEX);
                    bus.dataIn <= DBITS'(keyCount);
                end
                S_WR_HEX: begin
                    state      <= S_WAIT;
                    bus.wrMEM  <= 1'b0;
                    bus.addr   <= '0;
                    bus.dataIn <= '0;
                    wait_cnt   <= POLL_WAIT - 32'd1;
                end
                S_WAIT: begin
                    if (wait_cnt == 32'd0) begin
                        if (en) begin
                            state    <= S_RD_SW;
                            bus.addr <= DBITS'(ADDR_SW);
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    bus.wrMEM  <= 1'b0;
                    bus.addr   <= '0;
                    bus.dataIn <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_poll_master.sv
// Directed bench for io_poll_master with a small DataMemory model attached.
module tb_io_poll_master;
    import io_poll_master_pkg::*;

    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] keyCount;
    logic        busy;

    logic [9:0]  sw = '0;
    logic [3:0]  keys = '0;

    logic [31:0] ledr = '0, ledg = '0, hex = '0;
    logic [31:0] prev_addr = '0;
    logic        prev_wr = 1'b0;
    int n_ledr = 0, n_ledg = 0, n_hex = 0, n_start = 0;
    int cyc = 0, hex_cyc = 0, start_cyc = 0;
    int dbl_wr = 0, bad_wr = 0;

    int vectors = 0;
    int miscompares = 0;

    io_poll_master_if #(.DBITS(32)) bus ();

    io_poll_master #(.POLL_WAIT(32'(PW)), .DBITS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .bus      (bus),
        .keyCount (keyCount),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // DataMemory model: registered reads, write logging, strobe sanity counters.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_addr <= bus.addr;
        prev_wr   <= bus.wrMEM;
        if (bus.wrMEM) begin
            if (prev_wr && (prev_addr == bus.addr)) dbl_wr <= dbl_wr + 1;
            case (bus.addr)
                ADDR_LEDR: begin ledr <= bus.dataIn; n_ledr <= n_ledr + 1; end
                ADDR_LEDG: begin ledg <= bus.dataIn; n_ledg <= n_ledg + 1; end
                ADDR_HEX:  begin hex <= bus.dataIn; n_hex <= n_hex + 1; hex_cyc <= cyc; end
                default:   bad_wr <= bad_wr + 1;
            endcase
            bus.dataOut <= '0;
        end else begin
            if (bus.addr == ADDR_SW)       bus.dataOut <= {22'b0, sw};
            else if (bus.addr == ADDR_KEY) bus.dataOut <= {28'b0, keys};
            else                           bus.dataOut <= '0;
            if ((bus.addr == ADDR_SW) && (prev_addr != ADDR_SW)) begin
                start_cyc <= cyc;
                n_start   <= n_start + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_hex(input int budget, output bit ok);
        int h0;
        h0 = n_hex;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_hex != h0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        int s0;
        s0 = n_start;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_start != s0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_state(input state_t s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.state == s) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        vectors++; if (dut.state !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE); end
        vectors++; if (bus.wrMEM !== 1'b0) begin miscompares++; $display("FAIL reset_wrmem: got %b want 0", bus.wrMEM); end
        vectors++; if (bus.addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", bus.addr); end
        vectors++; if (bus.dataIn !== 32'h0) begin miscompares++; $display("FAIL reset_datain: got %h want 0", bus.dataIn); end
        vectors++; if (keyCount !== 16'h0) begin miscompares++; $display("FAIL reset_keycount: got %h want 0", keyCount); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_poll();
        bit ok;
        int st0;
        sw = 10'b1010101010; keys = 4'b0000; en = 1'b1;
        wait_hex(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_hex_timeout: got none want HEX write"); end
        st0 = start_cyc;
        vectors++; if (ledr !== 32'h0000_02AA) begin miscompares++; $display("FAIL basic_ledr: got %h want 000002aa", ledr); end
        vectors++; if (ledg !== 32'h0) begin miscompares++; $display("FAIL basic_ledg: got %h want 0", ledg); end
        vectors++; if (hex !== 32'h0) begin miscompares++; $display("FAIL basic_hex: got %h want 0", hex); end
        vectors++; if (hex_cyc - st0 !== 6) begin miscompares++; $display("FAIL basic_latency: got %0d want 6", hex_cyc - st0); end
        vectors++; if (busy !== 1'b0 || bus.wrMEM !== 1'b0 || bus.addr !== 32'h0 || bus.dataIn !== 32'h0) begin
            miscompares++; $display("FAIL basic_wait_outputs: got busy=%b wr=%b addr=%h din=%h want 0 0 0 0", busy, bus.wrMEM, bus.addr, bus.dataIn);
        end
        wait_start(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_restart_timeout: got none want new poll"); end
        vectors++; if (start_cyc - hex_cyc !== PW + 1) begin miscompares++; $display("FAIL basic_wait_len: got %0d want %0d", start_cyc - hex_cyc, PW + 1); end
    endtask

    task automatic test_key_press();
        bit ok;
        keys = 4'b0101;
        wait_hex(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL key1_timeout: got none want HEX write"); end
        vectors++; if (keyCount !== 16'd1) begin miscompares++; $display("FAIL key1_count: got %h want 0001", keyCount); end
        vectors++; if (hex !== 32'h1) begin miscompares++; $display("FAIL key1_hex: got %h want 00000001", hex); end
        vectors++; if (ledg !== 32'h5) begin miscompares++; $display("FAIL key1_ledg: got %h want 00000005", ledg); end
        wait_hex(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL key2_timeout: got none want HEX write"); end
        vectors++; if (keyCount !== 16'd1) begin miscompares++; $display("FAIL key2_count_held: got %h want 0001", keyCount); end
        vectors++; if (hex !== 32'h1) begin miscompares++; $display("FAIL key2_hex: got %h want 00000001", hex); end
    endtask

    task automatic test_multi_edge();
        bit ok;
        keys = 4'b1111;
        wait_hex(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL multi_timeout: got none want HEX write"); end
        vectors++; if (keyCount !== 16'd2) begin miscompares++; $display("FAIL multi_count: got %h want 0002", keyCount); end
        vectors++; if (hex !== 32'h2) begin miscompares++; $display("FAIL multi_hex: got %h want 00000002", hex); end
        vectors++; if (ledg !== 32'hF) begin miscompares++; $display("FAIL multi_ledg: got %h want 0000000f", ledg); end
        keys = 4'b0000;
        wait_hex(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL release_timeout: got none want HEX write"); end
        vectors++; if (keyCount !== 16'd2) begin miscompares++; $display("FAIL release_count: got %h want 0002", keyCount); end
    endtask

    task automatic test_wrap();
        bit ok;
        force dut.u_kpc.count = 16'hFFFF;
        #1;
        release dut.u_kpc.count;
        keys = 4'b0001;
        wait_hex(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got none want HEX write"); end
        vectors++; if (keyCount !== 16'h0000) begin miscompares++; $display("FAIL wrap_count: got %h want 0000", keyCount); end
        vectors++; if (hex !== 32'h0) begin miscompares++; $display("FAIL wrap_hex: got %h want 00000000", hex); end
    endtask

    task automatic test_en_drop();
        bit ok;
        int r0, g0, h0, s0;
        wait_start(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL drop_start_timeout: got none want new poll"); end
        tick(1);
        vectors++; if (dut.state !== S_RD_KEY) begin miscompares++; $display("FAIL drop_sync: got %0d want %0d", dut.state, S_RD_KEY); end
        r0 = n_ledr; g0 = n_ledg; h0 = n_hex;
        en = 1'b0;
        wait_state(S_IDLE, 30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL drop_idle_timeout: got %0d want S_IDLE", dut.state); end
        vectors++; if (n_ledr - r0 !== 1 || n_ledg - g0 !== 1 || n_hex - h0 !== 1) begin
            miscompares++; $display("FAIL drop_writes: got ledr=%0d ledg=%0d hex=%0d want 1 1 1", n_ledr - r0, n_ledg - g0, n_hex - h0);
        end
        s0 = n_start;
        tick(10);
        vectors++; if (dut.state !== S_IDLE || n_start !== s0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL drop_stays_idle: got state=%0d starts=%0d busy=%b want S_IDLE 0 0", dut.state, n_start - s0, busy);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        int h0;
        keys = 4'b0011; en = 1'b1;
        wait_state(S_WR_LEDG, 30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_sync_timeout: got %0d want S_WR_LEDG", dut.state); end
        vectors++; if (keyCount !== 16'd1) begin miscompares++; $display("FAIL rst_pre_count: got %h want 0001", keyCount); end
        h0 = n_hex;
        reset = 1'b1;
        tick(1);
        vectors++; if (bus.wrMEM !== 1'b0 || bus.addr !== 32'h0 || bus.dataIn !== 32'h0) begin
            miscompares++; $display("FAIL rst_bus: got wr=%b addr=%h din=%h want 0 0 0", bus.wrMEM, bus.addr, bus.dataIn);
        end
        vectors++; if (keyCount !== 16'h0 || dut.sw_reg !== 10'h0 || dut.u_kpc.key_reg !== 4'h0 || dut.u_kpc.key_prev !== 4'h0) begin
            miscompares++; $display("FAIL rst_regs: got cnt=%h sw=%h key=%h prev=%h want 0 0 0 0", keyCount, dut.sw_reg, dut.u_kpc.key_reg, dut.u_kpc.key_prev);
        end
        vectors++; if (dut.state !== S_IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL rst_state: got %0d busy=%b want S_IDLE 0", dut.state, busy); end
        reset = 1'b0;
        tick(1);
        vectors++; if (bus.wrMEM !== 1'b0) begin miscompares++; $display("FAIL rst_release_wrmem: got %b want 0", bus.wrMEM); end
        tick(2);
        vectors++; if (n_hex !== h0) begin miscompares++; $display("FAIL rst_no_hex: got %0d writes want 0", n_hex - h0); end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_poll();
        test_key_press();
        test_multi_edge();
        test_wrap();
        test_en_drop();
        test_reset_mid_write();
        vectors++; if (dbl_wr !== 0) begin miscompares++; $display("FAIL double_strobe: got %0d want 0", dbl_wr); end
        vectors++; if (bad_wr !== 0) begin miscompares++; $display("FAIL stray_write: got %0d want 0", bad_wr); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
